roberto_rx_pacote: RTL

Receive-side control and datapath for the sensor serial link. It consumes bytes from a UART receiver (one-cycle `pronto_rx` strobe plus `dado_rx`) and parses `N_SENS` frames, each `N_DIG` ASCII digits followed by the '#' terminator. Each valid frame is stored as packed BCD. Completion, error code and debug state are reported to the host FSM. It is the counterpart of the transmit sequencing unit that emits these frames.

---
 rtl/roberto_pkg.sv | 28 ++
 rtl/roberto_timeout.sv | 30 +++
 rtl/roberto_rx_pacote.sv | 139 +++++++++++++
 3 files changed

// File: rtl/roberto_pkg.sv
// Shared definitions for the sensor-link receive path:
// FSM encodings, ASCII framing constants and error codes.
package roberto_pkg;

  typedef enum logic [2:0] {
    INICIAL     = 3'b000,
    ESPERA      = 3'b001,
    ARMAZENA    = 3'b010,
    VERIFICA    = 3'b011,
    PROX_SENSOR = 3'b100,
    EST_FINAL   = 3'b101,
    EST_ERRO    = 3'b110
  } estado_t;

  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_9    = 8'h39;
  localparam logic [7:0] ASCII_TERM = 8'h23;

  localparam logic [1:0] COD_NONE    = 2'b00;
  localparam logic [1:0] COD_DIGITO  = 2'b01;
  localparam logic [1:0] COD_TERM    = 2'b10;
  localparam logic [1:0] COD_TIMEOUT = 2'b11;

  function automatic logic eh_digito(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

endpackage

// File: rtl/roberto_timeout.sv
// Inter-byte watchdog: counts while enabled, flags fim
// at TIMEOUT-1 and holds there until cleared.
module roberto_timeout #(
  parameter int TIMEOUT = 5_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LIMITE = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  assign fim = (cnt == LIMITE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (zera) begin
      cnt <= '0;
    end else if (conta && !fim) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/roberto_rx_pacote.sv
// Receive-side packet parser: N_SENS frames of N_DIG ASCII
// digits plus '#', stored as packed BCD in medidas.
module roberto_rx_pacote #(
  parameter int N_SENS  = 2,
  parameter int N_DIG   = 3,
  parameter int TIMEOUT = 5_000_000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       receber,
  input  logic                       pronto_rx,
  input  logic [7:0]                 dado_rx,
  output logic [N_SENS*N_DIG*4-1:0]  medidas,
  output logic                       pronto,
  output logic                       erro,
  output logic [1:0]                 erro_cod,
  output logic [2:0]                 db_estado
);

  import roberto_pkg::*;

  localparam int FB = N_DIG * 4;
  localparam int DW = $clog2(N_DIG + 1);
  localparam int FW = $clog2(N_SENS + 1);
  localparam logic [DW-1:0] DIG_FIM = DW'(N_DIG);
  localparam logic [FW-1:0] FRM_FIM = FW'(N_SENS - 1);

  estado_t        state;
  logic [DW-1:0]  dig;
  logic [FW-1:0]  frm;
  logic [7:0]     rx_byte;
  logic [FB-1:0]  quadro;
  logic           fim;
  logic           zera;
  logic           conta;

  // The watchdog only runs while idle in espera; any strobe
  // or any other state restarts it from zero.
  assign conta     = (state == ESPERA);
  assign zera      = (state != ESPERA) || pronto_rx;
  assign db_estado = state;

  roberto_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clock(clock),
    .reset(reset),
    .zera (zera),
    .conta(conta),
    .fim  (fim)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= INICIAL;
      dig      <= '0;
      frm      <= '0;
      rx_byte  <= '0;
      quadro   <= '0;
      medidas  <= '0;
      pronto   <= 1'b0;
      erro     <= 1'b0;
      erro_cod <= COD_NONE;
    end else begin
      pronto <= 1'b0;
      erro   <= 1'b0;
      unique case (1'b1)
        (state == INICIAL): begin
          dig      <= '0;
          frm      <= '0;
          erro_cod <= COD_NONE;
          if (receber) state <= ESPERA;
        end
        (state == ESPERA): begin
          if (pronto_rx) begin
            rx_byte <= dado_rx;
            state   <= (dig < DIG_FIM) ? ARMAZENA : VERIFICA;
          end else if (fim) begin
            state    <= EST_ERRO;
            erro     <= 1'b1;
            erro_cod <= COD_TIMEOUT;
          end
        end
        (state == ARMAZENA): begin
          if (eh_digito(rx_byte)) begin
            quadro <= FB'({quadro, rx_byte[3:0]});
            dig    <= dig + 1'b1;
            state  <= ESPERA;
          end else begin
            state    <= EST_ERRO;
            erro     <= 1'b1;
            erro_cod <= COD_DIGITO;
          end
        end
        (state == VERIFICA): begin
          if (rx_byte == ASCII_TERM) begin
            medidas[int'(frm)*FB +: FB] <= quadro;
            state <= PROX_SENSOR;
          end else begin
            state    <= EST_ERRO;
            erro     <= 1'b1;
            erro_cod <= COD_TERM;
          end
        end
        (state == PROX_SENSOR): begin
          frm <= frm + 1'b1;
          dig <= '0;
          if (frm == FRM_FIM) begin
            state  <= EST_FINAL;
            pronto <= 1'b1;
          end else begin
            state <= ESPERA;
          end
        end
        (state == EST_FINAL): begin
          if (receber) begin
            dig   <= '0;
            frm   <= '0;
            state <= ESPERA;
          end else begin
            pronto <= 1'b1;
          end
        end
        (state == EST_ERRO): begin
          if (receber) begin
            dig      <= '0;
            frm      <= '0;
            erro_cod <= COD_NONE;
            state    <= ESPERA;
          end else begin
            erro <= 1'b1;
          end
        end
        default: state <= INICIAL;
      endcase
    end
  end

endmodule
